// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder.
//   spi_state_e       : frame FSM states
//   spi_mode_e        : {cpol,cpoh} mode encoding
//   MIN_SCK_HALF_CLKS : minimum sck half-period in clk cycles
//   CNT_W / sat_inc   : saturating bit counter width and increment
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        RESP = 3'd2,
        DATA = 3'd3,
        TAIL = 3'd4
    } spi_state_e;

    // Bit 1 is cpol (sck idle level), bit 0 is cpoh (0 = sample on leading edge).
    typedef enum logic [1:0] {
        MODE_0 = 2'b00,
        MODE_1 = 2'b01,
        MODE_2 = 2'b10,
        MODE_3 = 2'b11
    } spi_mode_e;

    localparam int MIN_SCK_HALF_CLKS = 4;
    localparam int CNT_W             = 4;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer with edge pulses.
//   clk, reset : system clock, asynchronous active-low reset
//   din        : asynchronous input
//   sync       : synchronized level (last synchronizer stage)
//   rise, fall : one-cycle pulses from the last two synchronized samples
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_reg;
    logic              prev_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain_reg <= {STAGES{RESET_VAL}};
            prev_reg  <= RESET_VAL;
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], din};
            prev_reg  <= chain_reg[STAGES-1];
        end
    end

    assign sync = chain_reg[STAGES-1];
    assign rise = sync & ~prev_reg;
    assign fall = ~sync & prev_reg;

endmodule

// File: rtl/spi_slave.sv
// SPI responder: receives an address on mosi, then returns a host-supplied
// word on miso. All four cpol/cpoh modes, LSB first, sck/ss/mosi oversampled.
//   clk, reset        : system clock (>= 8x sck), asynchronous active-low reset
//   cpol, cpoh        : mode, latched at frame start
//   sck, ss, mosi     : SPI inputs from the master (asynchronous)
//   tx_data           : response word, valid while addr_valid is high
//   miso, miso_oe     : serial response and its driver enable
//   rx_addr           : last received address
//   addr_valid        : pulse when rx_addr updates
//   done, frame_err   : pulse on normal completion / abort
//   busy              : frame in progress
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpol,
    input  logic              cpoh,
    input  logic              sck,
    input  logic              ss,
    input  logic              mosi,
    input  logic [DATA_W-1:0] tx_data,
    output logic              miso,
    output logic              miso_oe,
    output logic [DATA_W-1:0] rx_addr,
    output logic              addr_valid,
    output logic              done,
    output logic              frame_err,
    output logic              busy
);

    localparam int IDX_W = $clog2(DATA_W);

    logic sck_rise, sck_fall, ss_rise, ss_fall, mosi_s;
    logic sck_level_unused, ss_level_unused, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .reset(reset), .din(sck),
        .sync(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
    );

    // ss idles high, so its synchronizer resets high to avoid a false frame start.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk), .reset(reset), .din(ss),
        .sync(ss_level_unused), .rise(ss_rise), .fall(ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .din(mosi),
        .sync(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_state_e        state_reg, state_next;
    spi_mode_e         mode_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] addr_sr_reg;
    logic [DATA_W-1:0] tx_sr_reg;
    logic [IDX_W-1:0]  idx;

    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic abort, finish;

    // Edge classification uses the mode latched at frame start.
    assign lead_edge   = mode_reg[1] ? sck_fall : sck_rise;
    assign trail_edge  = mode_reg[1] ? sck_rise : sck_fall;
    assign sample_edge = mode_reg[0] ? trail_edge : lead_edge;
    assign shift_edge  = mode_reg[0] ? lead_edge : trail_edge;
    assign idx         = cnt_reg[IDX_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        abort      = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE: if (ss_fall) state_next = ADDR;
            ADDR: begin
                if (ss_rise) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (cnt_reg == CNT_W'(DATA_W)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (ss_rise) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (ss_rise) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (sample_edge && cnt_reg == CNT_W'(DATA_W - 1)) begin
                    state_next = TAIL;
                end
            end
            TAIL: begin
                if (ss_rise) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_reg    <= MODE_0;
            cnt_reg     <= '0;
            addr_sr_reg <= '0;
            tx_sr_reg   <= '0;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            rx_addr     <= '0;
            addr_valid  <= 1'b0;
            done        <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            addr_valid <= 1'b0;
            done       <= 1'b0;
            frame_err  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (ss_fall) begin
                        mode_reg    <= spi_mode_e'({cpol, cpoh});
                        cnt_reg     <= '0;
                        addr_sr_reg <= '0;
                        miso        <= 1'b0;
                        miso_oe     <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                ADDR: begin
                    if (!ss_rise) begin
                        if (cnt_reg == CNT_W'(DATA_W)) begin
                            rx_addr    <= addr_sr_reg;
                            addr_valid <= 1'b1;
                        end else if (sample_edge) begin
                            addr_sr_reg[idx] <= mosi_s;
                            cnt_reg          <= sat_inc(cnt_reg);
                        end
                    end
                end
                RESP: begin
                    if (!ss_rise) begin
                        tx_sr_reg <= tx_data;
                        cnt_reg   <= '0;
                        // Leading-edge sampling needs bit0 on the wire before the first data edge.
                        if (!mode_reg[0]) miso <= tx_data[0];
                    end
                end
                DATA: begin
                    if (!ss_rise) begin
                        // With cnt = number of data samples taken, the next bit to present is
                        // tx[cnt]. In cpoh=0 the shift edge trailing the last address bit
                        // (cnt still 0) must not advance past bit0.
                        if (shift_edge && (mode_reg[0] || cnt_reg != '0))
                            miso <= tx_sr_reg[idx];
                        if (sample_edge)
                            cnt_reg <= sat_inc(cnt_reg);
                    end
                end
                default: ;
            endcase
            if (abort || finish) begin
                miso      <= 1'b0;
                miso_oe   <= 1'b0;
                busy      <= 1'b0;
                frame_err <= abort;
                done      <= finish;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;
    import spi_pkg::*;

    localparam int HALF_CLKS = MIN_SCK_HALF_CLKS + 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cpol = 1'b0, cpoh = 1'b0, sck = 1'b0, ss = 1'b1, mosi = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       miso, miso_oe, addr_valid, done, frame_err, busy;
    logic [7:0] rx_addr;

    int errors = 0;
    int checks = 0;
    int av_total = 0, done_total = 0, ferr_total = 0;
    logic [7:0] model_rx = 8'h00;

    spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .cpol(cpol), .cpoh(cpoh),
        .sck(sck), .ss(ss), .mosi(mosi), .tx_data(tx_data),
        .miso(miso), .miso_oe(miso_oe), .rx_addr(rx_addr),
        .addr_valid(addr_valid), .done(done), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Pulse monitor: counts high cycles of each pulse output.
    always @(negedge clk) begin
        if (addr_valid === 1'b1) av_total++;
        if (done === 1'b1)       done_total++;
        if (frame_err === 1'b1)  ferr_total++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic half();
        repeat (HALF_CLKS) @(negedge clk);
    endtask

    // Master model: drives sck/mosi for the given mode, samples miso on the sample
    // edges of the data phase. stop_at < 16 cuts the frame short.
    task automatic run_frame(input logic [1:0] mode, input logic [7:0] addr,
                             input logic [7:0] tx, input int stop_at,
                             input bit toggle_cpol, input bit rst_mid,
                             output logic [7:0] got);
        logic m_cpol, m_cpoh;
        m_cpol = mode[1];
        m_cpoh = mode[0];
        got    = 8'h00;
        @(negedge clk);
        cpol = m_cpol; cpoh = m_cpoh; sck = m_cpol; tx_data = tx; mosi = 1'b0;
        repeat (8) @(negedge clk);
        ss = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == stop_at) break;
            if (i == 3) begin
                check("busy_in_frame", 32'(busy), 32'd1);
                check("oe_in_frame", 32'(miso_oe), 32'd1);
            end
            if (toggle_cpol && i == 4) cpol = ~cpol;
            if (!m_cpoh) begin
                mosi = (i < 8) ? addr[i] : 1'($urandom);
                half();
                sck = ~m_cpol;
                if (i >= 8) got[i-8] = miso;
                half();
                sck = m_cpol;
            end else begin
                half();
                sck = ~m_cpol;
                mosi = (i < 8) ? addr[i] : 1'($urandom);
                half();
                sck = m_cpol;
                if (i >= 8) got[i-8] = miso;
            end
        end
        if (rst_mid) begin
            #1 reset = 1'b0;
            #1;
            check("rst_mid_miso", 32'(miso), 32'd0);
            check("rst_mid_oe", 32'(miso_oe), 32'd0);
            check("rst_mid_busy", 32'(busy), 32'd0);
            @(negedge clk);
            ss = 1'b1;
            sck = m_cpol;
            repeat (4) @(negedge clk);
            reset = 1'b1;
        end else begin
            half();
            ss = 1'b1;
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic do_frame(input string tag, input logic [1:0] mode, input logic [7:0] addr,
                            input logic [7:0] tx, input bit toggle_cpol);
        logic [7:0] got;
        int av0, d0, f0;
        av0 = av_total; d0 = done_total; f0 = ferr_total;
        run_frame(mode, addr, tx, 16, toggle_cpol, 1'b0, got);
        model_rx = addr;
        $display("frame %s mode=%0d addr=0x%02h tx=0x%02h rx_addr=0x%02h miso=0x%02h",
                 tag, mode, addr, tx, rx_addr, got);
        check({tag, "_rx_addr"}, 32'(rx_addr), 32'(model_rx));
        check({tag, "_miso"}, 32'(got), 32'(tx));
        check({tag, "_addr_valid"}, 32'(av_total - av0), 32'd1);
        check({tag, "_done"}, 32'(done_total - d0), 32'd1);
        check({tag, "_frame_err"}, 32'(ferr_total - f0), 32'd0);
        check({tag, "_oe_after"}, 32'(miso_oe), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] got;
        int av0, d0, f0;

        repeat (3) @(negedge clk);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_oe", 32'(miso_oe), 32'd0);
        check("rst_rx_addr", 32'(rx_addr), 32'd0);
        check("rst_addr_valid", 32'(addr_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        do_frame("m00", 2'b00, 8'h03, 8'h4C, 1'b0);
        do_frame("m01", 2'b01, 8'h08, 8'h77, 1'b0);
        do_frame("m10", 2'b10, 8'h01, 8'h20, 1'b1);
        do_frame("m11", 2'b11, 8'h07, 8'h33, 1'b0);

        // Abort after 5 address bits.
        av0 = av_total; d0 = done_total; f0 = ferr_total;
        run_frame(2'b00, 8'hA5, 8'h5A, 5, 1'b0, 1'b0, got);
        $display("frame abort mode=0 rx_addr=0x%02h frame_err_cycles=%0d", rx_addr, ferr_total - f0);
        check("abort_frame_err", 32'(ferr_total - f0), 32'd1);
        check("abort_addr_valid", 32'(av_total - av0), 32'd0);
        check("abort_done", 32'(done_total - d0), 32'd0);
        check("abort_rx_addr", 32'(rx_addr), 32'(model_rx));
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_oe", 32'(miso_oe), 32'd0);

        // Reset in the middle of the data phase.
        run_frame(2'b00, 8'h5A, 8'h96, 12, 1'b0, 1'b1, got);
        model_rx = 8'h00;
        $display("frame rst_mid rx_addr=0x%02h busy=%0b", rx_addr, busy);
        check("rst_mid_rx_addr", 32'(rx_addr), 32'(model_rx));
        do_frame("post_rst", 2'b00, 8'h3C, 8'hA1, 1'b0);

        for (int k = 0; k < 6; k++) begin
            logic [1:0] m;
            logic [7:0] a, t;
            m = 2'($urandom_range(0, 3));
            a = 8'($urandom);
            t = 8'($urandom);
            do_frame("rnd", m, a, t, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
